// File: rtl/note_playback_reader_if.sv
// Playback control, note output and note-memory read bus of note_playback_reader.
// The slave modport is the sequencer; the master modport is its controller and note memory.
interface note_playback_reader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              stop;
  logic [ADDR_W:0]   num_notes;
  logic [ADDR_W-1:0] mem_addr;
  logic [5:0]        mem_q;
  logic [3:0]        note_out;
  logic [1:0]        octave_out;
  logic              note_valid;
  logic [ADDR_W-1:0] note_index;
  logic              busy;
  logic              done;

  modport slave (
    input  start, stop, num_notes, mem_q,
    output mem_addr, note_out, octave_out, note_valid, note_index, busy, done
  );

  modport master (
    output start, stop, num_notes, mem_q,
    input  mem_addr, note_out, octave_out, note_valid, note_index, busy, done
  );
endinterface

// File: rtl/note_playback_reader.sv
// Note-memory playback sequencer: fetch each stored note, sound it, then hold a silent gap.
// Define LOOP_PLAYBACK_EN to repeat the sequence until stop instead of finishing after one pass.
module note_playback_reader #(
  parameter int ADDR_W     = 4,
  parameter int NOTE_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input  logic                  clk,
  input  logic                  reset,
  note_playback_reader_if.slave bus
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  NOTE_LOAD = CNT_W'(NOTE_TICKS);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        note_q, note_d;
  logic [1:0]        octave_q, octave_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              advance;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      note_q     <= '0;
      octave_q   <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every next-state value gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    note_d     = note_q;
    octave_d   = octave_q;
    valid_d    = valid_q;
    index_d    = index_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          count_d = bus.num_notes;
          if (bus.num_notes == '0) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            mem_addr_d = '0;
            busy_d     = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // RAM data for mem_addr_q is valid this cycle; capture it with its address.
        note_d   = bus.mem_q[3:0];
        octave_d = bus.mem_q[5:4];
        index_d  = mem_addr_q;
        valid_d  = (bus.mem_q[3:0] != 4'hF);
        cnt_d    = NOTE_LOAD;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        if (cnt_q == CNT_ONE) begin
          valid_d = 1'b0;
          if (GAP_TICKS == 0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_ONE) advance = 1'b1;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      S_FIN: begin
        busy_d     = 1'b0;
        mem_addr_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if ({1'b0, mem_addr_q} == count_q - COUNT_ONE) begin
        done_d = 1'b1;
`ifdef LOOP_PLAYBACK_EN
        mem_addr_d = '0;
        state_d    = S_FETCH;
`else
        state_d    = S_FIN;
`endif
      end else begin
        mem_addr_d = mem_addr_q + ADDR_ONE;
        state_d    = S_FETCH;
      end
    end

    // Abort returns everything to its reset value without a done pulse.
    if (bus.stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      mem_addr_d = '0;
      count_d    = '0;
      cnt_d      = '0;
      note_d     = '0;
      octave_d   = '0;
      valid_d    = 1'b0;
      index_d    = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.note_out   = note_q;
  assign bus.octave_out = octave_q;
  assign bus.note_valid = valid_q;
  assign bus.note_index = index_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_note_playback_reader.sv
// Bench for note_playback_reader: registered-address note RAM model plus a queue of expected notes,
// popped and compared at the cycle each note should start sounding.
module tb_note_playback_reader;
  localparam int ADDR_W     = 4;
  localparam int NOTE_TICKS = 4;
  localparam int GAP_TICKS  = 2;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [3:0]        note;
    logic [1:0]        oct;
    logic              valid;
  } exp_t;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [5:0]        mem [16];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  exp_t              exp_q[$];
  int                n_tests  = 0;
  int                n_fail   = 0;
  int                done_cnt = 0;

  note_playback_reader_if #(.ADDR_W(ADDR_W)) bus ();

  note_playback_reader #(
    .ADDR_W(ADDR_W), .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_addr_q <= bus.mem_addr;
  assign bus.mem_q = mem[ram_addr_q];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] outs();
    return {bus.mem_addr, bus.note_out, bus.octave_out, bus.note_valid,
            bus.note_index, bus.busy, bus.done};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.idx   = ADDR_W'(k);
      e.note  = mem[k][3:0];
      e.oct   = mem[k][5:4];
      e.valid = (mem[k][3:0] != 4'hF);
      exp_q.push_back(e);
    end
  endtask

  // Drives start just after an edge; returns just after the edge that samples it.
  task automatic start_playback(input int n);
    bus.num_notes = (ADDR_W+1)'(n);
    bus.start     = 1'b1;
    push_expected(n);
    tick(1);
    bus.start = 1'b0;
  endtask

  // Entered just after the edge that starts a fetch; leaves just after the edge ending the last gap.
  task automatic check_pass(input int n, input bit poke);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      if (poke && k == 0) begin
        bus.start     = 1'b1;
        bus.num_notes = (ADDR_W+1)'(1);
      end
      tick(1);
      bus.start = 1'b0;
      tick(1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: no expected note for slot %0d", k);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if ({bus.note_index, bus.note_out, bus.octave_out, bus.note_valid, bus.busy, bus.mem_addr}
            !== {e.idx, e.note, e.oct, e.valid, 1'b1, e.idx}) begin
          n_fail++;
          $display("FAIL note_start slot %0d: got idx=%0d note=%h oct=%0d valid=%b busy=%b addr=%0d, want idx=%0d note=%h oct=%0d valid=%b busy=1 addr=%0d",
                   k, bus.note_index, bus.note_out, bus.octave_out, bus.note_valid, bus.busy,
                   bus.mem_addr, e.idx, e.note, e.oct, e.valid, e.idx);
        end
        for (int t = 1; t < NOTE_TICKS; t++) begin
          tick(1);
          n_tests++;
          if (bus.note_valid !== e.valid) begin
            n_fail++;
            $display("FAIL note_hold slot %0d tick %0d: got valid=%b, want %b", k, t, bus.note_valid, e.valid);
          end
        end
        for (int t = 0; t < GAP_TICKS; t++) begin
          tick(1);
          n_tests++;
          if ({bus.note_valid, bus.note_out, bus.octave_out} !== {1'b0, e.note, e.oct}) begin
            n_fail++;
            $display("FAIL gap slot %0d tick %0d: got valid=%b note=%h oct=%0d, want valid=0 note=%h oct=%0d",
                     k, t, bus.note_valid, bus.note_out, bus.octave_out, e.note, e.oct);
          end
        end
      end
      tick(1);
    end
  endtask

  task automatic check_fin(input string name);
    n_tests++;
    if ({bus.done, bus.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s fin: got done=%b busy=%b, want done=1 busy=1", name, bus.done, bus.busy);
    end
    tick(1);
    n_tests++;
    if ({bus.done, bus.busy, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL %s idle: got done=%b busy=%b addr=%0d, want all 0", name, bus.done, bus.busy, bus.mem_addr);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    bus.num_notes = (ADDR_W+1)'(3);
    reset = 1'b0;
    tick(2);
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got outs=%h, want 0", outs());
    end
    bus.start = 1'b0;
    reset = 1'b1;
    tick(3);
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL start_in_reset: got outs=%h, want 0", outs());
    end
  endtask

  task automatic test_basic();
    int d0;
    mem[0] = 6'h12;
    mem[1] = 6'h0F;
    mem[2] = 6'h25;
    d0 = done_cnt;
    start_playback(3);
    n_tests++;
    if ({bus.busy, bus.mem_addr, bus.note_valid} !== {1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_accept: got busy=%b addr=%0d valid=%b, want busy=1 addr=0 valid=0",
               bus.busy, bus.mem_addr, bus.note_valid);
    end
    check_pass(3, 1'b1);
    check_fin("basic");
    n_tests++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d, want %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_zero();
    int d0;
    d0 = done_cnt;
    start_playback(0);
    n_tests++;
    if ({bus.done, bus.busy, bus.mem_addr} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b busy=%b addr=%0d, want done=1 busy=0 addr=0",
               bus.done, bus.busy, bus.mem_addr);
    end
    tick(1);
    n_tests++;
    if ({bus.done, bus.busy, bus.mem_addr} !== '0 || done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL zero_after: got done=%b busy=%b pulses=%0d, want done=0 busy=0 pulses=1",
               bus.done, bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_stop();
    int d0;
    d0 = done_cnt;
    start_playback(3);
    check_pass(1, 1'b0);
    tick(3);
    n_tests++;
    if ({bus.note_index, bus.busy} !== {4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL stop_pre: got idx=%0d busy=%b, want idx=1 busy=1", bus.note_index, bus.busy);
    end
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    exp_q.delete();
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL stop_clear: got outs=%h, want 0", outs());
    end
    tick(3);
    n_tests++;
    if (outs() !== '0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL stop_idle: got outs=%h pulses=%0d, want outs=0 pulses=0", outs(), done_cnt - d0);
    end
    start_playback(3);
    check_pass(3, 1'b0);
    check_fin("replay");
  endtask

  task automatic test_start_stop_same();
    int d0;
    d0 = done_cnt;
    bus.num_notes = (ADDR_W+1)'(3);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick(2);
    n_tests++;
    if ({bus.busy, bus.note_valid, bus.mem_addr, bus.done} !== '0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL start_stop: got busy=%b valid=%b addr=%0d pulses=%0d, want all 0",
               bus.busy, bus.note_valid, bus.mem_addr, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    start_playback(3);
    tick(4);
    n_tests++;
    if (bus.note_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got valid=%b, want 1", bus.note_valid);
    end
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    exp_q.delete();
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got outs=%h, want 0", outs());
    end
    tick(2);
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got outs=%h, want 0", outs());
    end
  endtask

  task automatic test_full();
    int d0;
    for (int k = 0; k < 16; k++) mem[k] = 6'(((k % 4) << 4) | (15 - k));
    d0 = done_cnt;
    start_playback(16);
    check_pass(16, 1'b0);
    check_fin("full");
    tick(4);
    n_tests++;
    if ({bus.busy, bus.mem_addr} !== '0 || done_cnt !== d0 + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_end: got busy=%b addr=%0d pulses=%0d left=%0d, want busy=0 addr=0 pulses=1 left=0",
               bus.busy, bus.mem_addr, done_cnt - d0, exp_q.size());
    end
  endtask

`ifdef LOOP_PLAYBACK_EN
  task automatic test_loop();
    int d0;
    mem[0] = 6'h12;
    mem[1] = 6'h0F;
    d0 = done_cnt;
    start_playback(2);
    for (int p = 0; p < 3; p++) begin
      if (p > 0) push_expected(2);
      check_pass(2, 1'b0);
      n_tests++;
      if ({bus.done, bus.busy, bus.mem_addr} !== {1'b1, 1'b1, 4'h0}) begin
        n_fail++;
        $display("FAIL loop_wrap pass %0d: got done=%b busy=%b addr=%0d, want done=1 busy=1 addr=0",
                 p, bus.done, bus.busy, bus.mem_addr);
      end
    end
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    exp_q.delete();
    n_tests++;
    if ({bus.busy, bus.note_valid, bus.done} !== '0 || done_cnt !== d0 + 3) begin
      n_fail++;
      $display("FAIL loop_stop: got busy=%b valid=%b pulses=%0d, want busy=0 valid=0 pulses=3",
               bus.busy, bus.note_valid, done_cnt - d0);
    end
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.num_notes = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    test_reset();
`ifdef LOOP_PLAYBACK_EN
    test_loop();
`else
    test_basic();
    test_zero();
    test_stop();
    test_start_stop_same();
    test_reset_mid();
    test_full();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
